// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for the shared RAM rd1/write ports, with capped locked bursts.
// Zero-cycle grant; read data registered and returned one cycle after the grant.
module ram_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int MASK_WIDTH = DATA_WIDTH >> 3,
  parameter int MAX_BURST  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic                  i_a_lock,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [MASK_WIDTH-1:0] i_a_mask,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic                  i_b_lock,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [MASK_WIDTH-1:0] i_b_mask,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_a_gnt,
  output logic                  o_b_gnt,
  output logic                  o_a_rvalid,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  output logic [MASK_WIDTH-1:0] o_ram_rd_mask,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [MASK_WIDTH-1:0] o_ram_wr_mask,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t          state;
  logic            ptr;    // 0 = A has priority, 1 = B has priority
  logic [CW-1:0]   cnt;

  logic            hold_a;
  logic            hold_b;
  logic            any_gnt;
  logic            sel_we;
  logic            sel_lock;
  logic [CW-1:0]   cnt_nxt;

  // An owner that drops req releases immediately; that cycle falls through to normal arbitration.
  assign hold_a = (state == OWN_A) && i_a_req;
  assign hold_b = (state == OWN_B) && i_b_req;

  always_comb begin
    o_a_gnt = 1'b0;
    o_b_gnt = 1'b0;
    if (i_rst_n) begin
      if (hold_a) begin
        o_a_gnt = 1'b1;
      end else if (hold_b) begin
        o_b_gnt = 1'b1;
      end else if (i_a_req && i_b_req) begin
        o_a_gnt = ~ptr;
        o_b_gnt = ptr;
      end else begin
        o_a_gnt = i_a_req;
        o_b_gnt = i_b_req;
      end
    end
  end

  assign any_gnt  = o_a_gnt | o_b_gnt;
  assign sel_we   = o_b_gnt ? i_b_we   : i_a_we;
  assign sel_lock = o_b_gnt ? i_b_lock : i_a_lock;
  assign cnt_nxt  = (hold_a | hold_b) ? cnt + CW'(1) : CW'(1);

  assign o_ram_rd_en   = any_gnt & ~sel_we;
  assign o_ram_wr_en   = any_gnt & sel_we;
  assign o_ram_rd_addr = o_b_gnt ? i_b_addr : i_a_addr;
  assign o_ram_rd_mask = o_b_gnt ? i_b_mask : i_a_mask;
  assign o_ram_wr_addr = o_b_gnt ? i_b_addr : i_a_addr;
  assign o_ram_wr_mask = o_b_gnt ? i_b_mask : i_a_mask;
  assign o_ram_wr_data = o_b_gnt ? i_b_wdata : i_a_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      o_a_rvalid <= 1'b0;
      o_b_rvalid <= 1'b0;
      o_a_rdata  <= '0;
      o_b_rdata  <= '0;
    end else begin
      o_a_rvalid <= o_a_gnt & ~i_a_we;
      o_b_rvalid <= o_b_gnt & ~i_b_we;
      if (o_a_gnt && !i_a_we) o_a_rdata <= i_ram_rd_data;
      if (o_b_gnt && !i_b_we) o_b_rdata <= i_ram_rd_data;
      if (any_gnt) begin
        ptr <= o_a_gnt;
        // Stay owned only while lock is held and the burst cap has not been reached.
        if (sel_lock && (cnt_nxt < CW'(MAX_BURST))) begin
          state <= o_a_gnt ? OWN_A : OWN_B;
          cnt   <= cnt_nxt;
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: ideal RAM, per-cycle behavioural model check, and directed scenarios.
module tb_ram_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [7:0]  addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } req_t;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  req_t        ra = '0;
  req_t        rb = '0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [63:0] a_rdata, b_rdata;
  logic        rd_en, wr_en;
  logic [7:0]  rd_addr, rd_mask, wr_addr, wr_mask;
  logic [63:0] rd_data, wr_data;
  logic [63:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .MASK_WIDTH(8), .MAX_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(ra.req), .i_a_we(ra.we), .i_a_lock(ra.lock),
    .i_a_addr(ra.addr), .i_a_mask(ra.mask), .i_a_wdata(ra.wdata),
    .i_b_req(rb.req), .i_b_we(rb.we), .i_b_lock(rb.lock),
    .i_b_addr(rb.addr), .i_b_mask(rb.mask), .i_b_wdata(rb.wdata),
    .o_a_gnt(a_gnt), .o_b_gnt(b_gnt),
    .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
    .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
    .o_ram_rd_en(rd_en), .o_ram_rd_addr(rd_addr), .o_ram_rd_mask(rd_mask),
    .i_ram_rd_data(rd_data),
    .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr), .o_ram_wr_mask(wr_mask),
    .o_ram_wr_data(wr_data)
  );

  assign rd_data = mem[rd_addr[7:3]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner 0=none 1=A 2=B, beats = accesses in current lock, pri 0=A 1=B.
  int          owner, beats, pri;
  bit          pa, pb;
  logic [63:0] ea, eb;

  always @(negedge clk) begin
    bit   ga, gb, any;
    req_t x;
    if (!rst_n) begin
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      owner = 0; beats = 0; pri = 0; pa = 0; pb = 0; ea = '0; eb = '0;
    end else begin
      ga = 0; gb = 0;
      if (owner == 1 && ra.req) ga = 1;
      else if (owner == 2 && rb.req) gb = 1;
      else if (ra.req && rb.req) begin
        if (pri == 0) ga = 1; else gb = 1;
      end else begin
        ga = ra.req; gb = rb.req;
      end
      any = ga | gb;
      x = gb ? rb : ra;
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
      chk("rd_en", rd_en, any && !x.we);
      chk("wr_en", wr_en, any && x.we);
      if (any && !x.we) begin
        chk("rd_addr", rd_addr, x.addr);
        chk("rd_mask", rd_mask, x.mask);
      end
      if (any && x.we) begin
        chk("wr_addr", wr_addr, x.addr);
        chk("wr_mask", wr_mask, x.mask);
        chk("wr_data", wr_data, x.wdata);
      end
      chk("a_rvalid", a_rvalid, pa);
      chk("b_rvalid", b_rvalid, pb);
      chk("a_rdata", a_rdata, ea);
      chk("b_rdata", b_rdata, eb);
      pa = ga && !x.we;
      pb = gb && !x.we;
      if (pa) ea = mem[x.addr[7:3]];
      if (pb) eb = mem[x.addr[7:3]];
      if (any && x.we)
        for (int i = 0; i < 8; i++)
          if (x.mask[i]) mem[x.addr[7:3]][8*i +: 8] = x.wdata[8*i +: 8];
      if (any) begin
        if (owner == (ga ? 1 : 2)) beats++; else beats = 1;
        pri = ga ? 1 : 0;
        if (x.lock && beats < MAXB) owner = ga ? 1 : 2;
        else begin owner = 0; beats = 0; end
      end else begin
        owner = 0; beats = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 0; ra = '0; rb = '0;
    nxt();
    nxt();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nb;
    for (int i = 0; i < 32; i++) mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    smp();
    smp();
    nxt();
    rst_n = 1;

    // A single read of word 1
    nxt();
    ra = '{1'b1, 1'b0, 1'b0, 8'h08, 8'hFF, 64'h0};
    smp();
    chk("s1_a_gnt", a_gnt, 1);
    chk("s1_b_gnt", b_gnt, 0);
    nxt();
    ra = '0;
    smp();
    chk("s1_a_rvalid", a_rvalid, 1);
    chk("s1_a_rdata", a_rdata, 64'hC0DE_0000_0000_0001);
    chk("s1_b_rvalid", b_rvalid, 0);
    chk("s1_b_rdata", b_rdata, 0);

    // Round-robin alternation from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      nxt();
      ra = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 64'h0};
      rb = '{1'b1, 1'b0, 1'b0, 8'h20, 8'hFF, 64'h0};
      smp();
      chk("s2_grant_seq", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    nxt();
    ra = '0; rb = '0;

    // Locked B burst capped at MAXB while A waits
    do_reset();
    nb = 0;
    nxt();
    rb = '{1'b1, 1'b1, 1'b1, 8'h40, 8'hFF, 64'h0};
    smp();
    chk("s3_first_b", {a_gnt, b_gnt}, 2'b01);
    if (b_gnt) nb++;
    for (int c = 1; c < 10; c++) begin
      nxt();
      ra = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 64'h0};
      rb = '{1'b1, 1'b1, (nb < 12), 8'(8'h40 + 8 * nb), 8'hFF, 64'(nb)};
      smp();
      chk("s3_burst_seq", {a_gnt, b_gnt}, (c < 8) ? 2'b01 : (c == 8) ? 2'b10 : 2'b01);
      if (b_gnt) nb++;
    end
    nxt();
    ra = '0; rb = '0;

    // B drops req mid-lock: A takes that cycle
    do_reset();
    nxt();
    rb = '{1'b1, 1'b1, 1'b1, 8'h60, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD};
    smp();
    chk("s4_beat1", {a_gnt, b_gnt}, 2'b01);
    for (int c = 0; c < 2; c++) begin
      nxt();
      ra = '{1'b1, 1'b0, 1'b0, 8'h08, 8'hFF, 64'h0};
      smp();
      chk("s4_beat_b", {a_gnt, b_gnt}, 2'b01);
    end
    nxt();
    rb.req = 0;
    smp();
    chk("s4_release_a", {a_gnt, b_gnt}, 2'b10);
    nxt();
    rb = '{1'b1, 1'b0, 1'b0, 8'h68, 8'hFF, 64'h0};
    smp();
    chk("s4_idle_rr_b", {a_gnt, b_gnt}, 2'b01);
    nxt();
    ra = '0; rb = '0;

    // Masked write then read-back
    do_reset();
    nxt();
    ra = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h0F, 64'h1122_3344_5566_7788};
    smp();
    chk("s5_wr_gnt", a_gnt, 1);
    chk("s5_wr_en", wr_en, 1);
    nxt();
    ra = '{1'b1, 1'b0, 1'b0, 8'h10, 8'hFF, 64'h0};
    smp();
    chk("s5_rd_en", rd_en, 1);
    chk("s5_rvalid_early", a_rvalid, 0);
    nxt();
    ra = '0;
    smp();
    chk("s5_rvalid", a_rvalid, 1);
    chk("s5_rdata", a_rdata, 64'hC0DE_0000_5566_7788);
    nxt();
    smp();
    chk("s5_rvalid_end", a_rvalid, 0);

    // Reset right after a B read grant drops the response
    do_reset();
    nxt();
    rb = '{1'b1, 1'b0, 1'b0, 8'h18, 8'hFF, 64'h0};
    smp();
    chk("s6_b_gnt", b_gnt, 1);
    nxt();
    rb = '0;
    rst_n = 0;
    smp();
    chk("s6_b_rvalid_rst", b_rvalid, 0);
    chk("s6_b_rdata_rst", b_rdata, 0);
    nxt();
    nxt();
    rst_n = 1;
    smp();
    chk("s6_b_rvalid_after", b_rvalid, 0);
    nxt();
    ra = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 64'h0};
    rb = '{1'b1, 1'b0, 1'b0, 8'h18, 8'hFF, 64'h0};
    smp();
    chk("s6_ptr_a", {a_gnt, b_gnt}, 2'b10);
    nxt();
    ra = '0; rb = '0;
    smp();
    chk("s6_a_rvalid", a_rvalid, 1);
    chk("s6_a_rdata", a_rdata, 64'hC0DE_0000_0000_0000);
    nxt();
    smp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter in front of the banked `ram` block. It shares the RAM read port (rd1) and write port between requester A (core load/store) and requester B (loader/debug DMA), one access per cycle. It uses a round-robin priority pointer and an optional locked burst, capped at MAX_BURST accesses, for B-side block transfers. Read data is registered and returned one cycle after acceptance.

## Interface
Parameters:
- DATA_WIDTH, 64, RAM word width.
- ADDR_WIDTH, 8, byte address width, passed straight to the RAM.
- MASK_WIDTH, DATA_WIDTH>>3, byte-enable width.
- MAX_BURST, 8, maximum consecutive accesses per lock (≥1; value 1 disables locking).

Ports:
- i_clk  in  1  the single clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_a_req / i_b_req  in  1  access request.
- i_a_we / i_b_we  in  1  1 = write, 0 = read.
- i_a_lock / i_b_lock  in  1  request to keep ownership after this access.
- i_a_addr / i_b_addr  in  ADDR_WIDTH  byte address.
- i_a_mask / i_b_mask  in  MASK_WIDTH  byte enables.
- i_a_wdata / i_b_wdata  in  DATA_WIDTH  write data.
- o_a_gnt / o_b_gnt  out  1  access accepted this cycle (combinational).
- o_a_rvalid / o_b_rvalid  out  1  read data valid, one-cycle pulse.
- o_a_rdata / o_b_rdata  out  DATA_WIDTH  registered read data.
- o_ram_rd_en, o_ram_rd_addr, o_ram_rd_mask  out  1/ADDR_WIDTH/MASK_WIDTH  to RAM rd1.
- i_ram_rd_data  in  DATA_WIDTH  from RAM rd1, combinational.
- o_ram_wr_en, o_ram_wr_addr, o_ram_wr_mask, o_ram_wr_data  out  1/ADDR_WIDTH/MASK_WIDTH/DATA_WIDTH  to RAM write port.

## Operation
- States: IDLE, OWN_A, OWN_B. Also held: priority pointer `ptr` (A or B) and burst counter `cnt` (width clog2(MAX_BURST)+1).
- **IDLE arbitration:**
  - Only one requester asserts req: it is granted.
  - Both assert req: the requester selected by `ptr` is granted.
  - Neither asserts req: no grant, and `ptr` holds.
- **OWN_X:**
  - If X asserts req, only X can be granted; the other requester sees gnt=0 and stalls.
  - If X drops req, ownership is released combinationally. That cycle is arbitrated as IDLE and the state returns to IDLE.
- **Granted access:**
  - Write (we=1): drive o_ram_wr_en=1 and pass addr/mask/wdata through. The RAM commits at the same edge.
  - Read (we=0): drive o_ram_rd_en=1 and pass addr/mask through. Capture i_ram_rd_data into o_X_rdata at the edge, and pulse o_X_rvalid the next cycle.
- The RAM enables are 0 whenever there is no grant. At most one of o_a_gnt/o_b_gnt is high in any cycle.
- **After every grant to X:** `ptr` points to the other requester.
- **Lock and burst counting:**
  - A grant with i_X_lock=1 from IDLE enters OWN_X with cnt=1. This requires MAX_BURST>1; otherwise the state stays IDLE.
  - Each grant in OWN_X increments cnt.
  - OWN_X exits to IDLE after the grant where lock=0 or cnt reaches MAX_BURST, whichever comes first.
- o_X_rdata holds its last value until the next read by X. Writes never update rdata.
- No read/write hazard is possible: only one access is issued per cycle.

## Timing
- **Reset (i_rst_n=0, asynchronous):**
  - State IDLE, ptr=A, cnt=0.
  - o_a_rvalid=o_b_rvalid=0, o_a_rdata=o_b_rdata=0.
  - Grants and RAM enables are 0 while reset is held.
- Grant latency: zero (same cycle as req). Read data latency: 1 cycle after grant. Write: committed at the edge ending the grant cycle.
- A read at address N in cycle t, with a write to N granted in t+1, returns the old data.
- **Reset mid-burst:** returns to IDLE immediately. Any pending rvalid is dropped; no response is issued after reset deassertion.
- Back-to-back reads by one requester give rvalid high on consecutive cycles.
- Requesters hold all request fields stable until gnt is sampled high.

## Test plan
- Reset, then A reads addr 0x08 with mask 0xFF → o_a_gnt=1 in the same cycle; next cycle o_a_rvalid=1 and o_a_rdata=RAM word 1; o_b_* stay 0.
- A and B both request every cycle, no lock, starting from reset → grants alternate A,B,A,B; ptr toggles after each grant.
- B writes with lock=1 for 12 beats (MAX_BURST=8) while A requests continuously → B gets 8 consecutive grants, then A is granted, then B resumes.
- B locks, then drops req after 3 beats while A is requesting → A is granted in the cycle B's req is low; state returns to IDLE.
- A writes 0x1122334455667788 with mask 0x0F to 0x10, then reads it back → low 4 bytes updated, upper bytes preserved, rvalid exactly 1 cycle after the read grant.
- Assert i_rst_n=0 in the cycle after a B read grant → o_b_rvalid stays 0; after release, state is IDLE and ptr=A.
